// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline flow control: load-use interlock, branch redirect/flush, memory-wait freeze.
// Optional memory watchdog enabled by defining PIPE_MEM_WATCHDOG_EN (adds MEM_ERR output).
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int FLUSH_W        = 2,
  parameter int LD_USE_BUBBLES = 1,
  parameter int CNT_W          = 16,
  parameter int MEM_WAIT_MAX   = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] ID_RS_ADD,
  input  logic [REG_ADDR_W-1:0] ID_RT_ADD,
  input  logic                  ID_USES_RT,
  input  logic [REG_ADDR_W-1:0] EX_RD_ADD,
  input  logic                  EX_IS_LD,
  input  logic                  EX_WB_EN,
  input  logic                  BRANCH_EX,
  input  logic                  MEM_REQ,
  input  logic                  MEM_READY,
  output logic                  PC_WE,
  output logic                  PC_SEL,
  output logic                  IF_ID_WE,
  output logic                  BUBBLE_EX,
  output logic [FLUSH_W-1:0]    FLUSH,
  output logic                  FREEZE,
`ifdef PIPE_MEM_WATCHDOG_EN
  output logic                  MEM_ERR,
`endif
  output logic [CNT_W-1:0]      STALL_CNT,
  output logic [CNT_W-1:0]      FLUSH_CNT
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_LDUSE = 2'd1;
  localparam logic [1:0] S_MWAIT = 2'd2;

  logic [1:0] state, state_nxt, ret, ret_nxt, eff_state;
  logic [2:0] bcnt, bcnt_nxt;
  logic       haz, mwait;

  assign haz = EX_IS_LD & EX_WB_EN & (EX_RD_ADD != '0) &
               ((EX_RD_ADD == ID_RS_ADD) | (ID_USES_RT & (EX_RD_ADD == ID_RT_ADD)));

`ifdef PIPE_MEM_WATCHDOG_EN
  localparam int WCNT_W = $clog2(MEM_WAIT_MAX + 1);
  logic [WCNT_W-1:0] wcnt;
  logic              mem_err;

  // Once the watchdog trips, memory waits no longer freeze the pipeline.
  assign mwait   = MEM_REQ & ~MEM_READY & ~mem_err;
  assign MEM_ERR = mem_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else if (mwait && state != S_MWAIT) begin
      wcnt <= '0;
    end else if (mwait && state == S_MWAIT) begin
      wcnt <= wcnt + {{(WCNT_W-1){1'b0}}, 1'b1};
      if (32'(wcnt) + 32'd1 >= MEM_WAIT_MAX)
        mem_err <= 1'b1;
    end
  end
`else
  assign mwait = MEM_REQ & ~MEM_READY;
`endif

  // Leaving MWAIT is zero-cycle: the saved state is evaluated as if it were current.
  always_comb begin
    PC_WE     = 1'b1;
    PC_SEL    = 1'b0;
    IF_ID_WE  = 1'b1;
    BUBBLE_EX = 1'b0;
    FLUSH     = '0;
    FREEZE    = 1'b0;
    state_nxt = state;
    ret_nxt   = ret;
    bcnt_nxt  = bcnt;
    eff_state = (state == S_MWAIT) ? ret : state;
    if (mwait) begin
      FREEZE    = 1'b1;
      PC_WE     = 1'b0;
      IF_ID_WE  = 1'b0;
      state_nxt = S_MWAIT;
      if (state != S_MWAIT)
        ret_nxt = state;
    end else begin
      state_nxt = eff_state;
      if (eff_state == S_RUN && BRANCH_EX) begin
        PC_SEL = 1'b1;
        FLUSH  = '1;
      end else if (eff_state == S_RUN && haz) begin
        PC_WE     = 1'b0;
        IF_ID_WE  = 1'b0;
        BUBBLE_EX = 1'b1;
        if (LD_USE_BUBBLES > 1) begin
          state_nxt = S_LDUSE;
          bcnt_nxt  = 3'(LD_USE_BUBBLES - 1);
        end
      end else if (eff_state == S_LDUSE) begin
        PC_WE     = 1'b0;
        IF_ID_WE  = 1'b0;
        BUBBLE_EX = 1'b1;
        bcnt_nxt  = bcnt - 3'd1;
        if (bcnt <= 3'd1)
          state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_RUN;
      ret   <= S_RUN;
      bcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if ((FREEZE || BUBBLE_EX) && STALL_CNT != '1)
        STALL_CNT <= STALL_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
      if (PC_SEL && FLUSH_CNT != '1)
        FLUSH_CNT <= FLUSH_CNT + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one single-bubble instance (a) and a 3-bubble,
// 4-bit-counter instance (b) share the same stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs_add, id_rt_add, ex_rd_add;
  logic       id_uses_rt, ex_is_ld, ex_wb_en, branch_ex, mem_req, mem_ready;

  logic        pc_we_a, pc_sel_a, if_id_we_a, bubble_a, freeze_a;
  logic [1:0]  flush_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic        pc_we_b, pc_sel_b, if_id_we_b, bubble_b, freeze_b;
  logic [1:0]  flush_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;
`ifdef PIPE_MEM_WATCHDOG_EN
  logic        mem_err_a, mem_err_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LD_USE_BUBBLES(1), .CNT_W(16)) dut_a (
    .CLK(clk), .RST(rst_n), .ID_RS_ADD(id_rs_add), .ID_RT_ADD(id_rt_add),
    .ID_USES_RT(id_uses_rt), .EX_RD_ADD(ex_rd_add), .EX_IS_LD(ex_is_ld),
    .EX_WB_EN(ex_wb_en), .BRANCH_EX(branch_ex), .MEM_REQ(mem_req), .MEM_READY(mem_ready),
    .PC_WE(pc_we_a), .PC_SEL(pc_sel_a), .IF_ID_WE(if_id_we_a), .BUBBLE_EX(bubble_a),
    .FLUSH(flush_a), .FREEZE(freeze_a),
`ifdef PIPE_MEM_WATCHDOG_EN
    .MEM_ERR(mem_err_a),
`endif
    .STALL_CNT(stall_cnt_a), .FLUSH_CNT(flush_cnt_a)
  );

  pipe_hazard_ctrl #(.LD_USE_BUBBLES(3), .CNT_W(4)) dut_b (
    .CLK(clk), .RST(rst_n), .ID_RS_ADD(id_rs_add), .ID_RT_ADD(id_rt_add),
    .ID_USES_RT(id_uses_rt), .EX_RD_ADD(ex_rd_add), .EX_IS_LD(ex_is_ld),
    .EX_WB_EN(ex_wb_en), .BRANCH_EX(branch_ex), .MEM_REQ(mem_req), .MEM_READY(mem_ready),
    .PC_WE(pc_we_b), .PC_SEL(pc_sel_b), .IF_ID_WE(if_id_we_b), .BUBBLE_EX(bubble_b),
    .FLUSH(flush_b), .FREEZE(freeze_b),
`ifdef PIPE_MEM_WATCHDOG_EN
    .MEM_ERR(mem_err_b),
`endif
    .STALL_CNT(stall_cnt_b), .FLUSH_CNT(flush_cnt_b)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic is_ld, input logic wb, input logic [4:0] rd,
                                input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                input logic br, input logic req, input logic rdy);
    ex_is_ld   = is_ld;
    ex_wb_en   = wb;
    ex_rd_add  = rd;
    id_rs_add  = rs;
    id_rt_add  = rt;
    id_uses_rt = uses_rt;
    branch_ex  = br;
    mem_req    = req;
    mem_ready  = rdy;
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int frz;
    rst_n = 1'b0;
    idle();
    check_output("rst_pc_we_a", pc_we_a, 1);
    check_output("rst_if_id_we_a", if_id_we_a, 1);
    check_output("rst_bubble_b", bubble_b, 0);
    check_output("rst_freeze_b", freeze_b, 0);
    check_output("rst_flush_a", flush_a, 0);
    check_output("rst_stall_a", stall_cnt_a, 0);
    check_output("rst_flushcnt_b", flush_cnt_b, 0);
    #9;
    rst_n = 1'b1;
    tick();

    // single and multi-bubble load-use on rs
    apply_stimulus(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("lu_pc_we_a", pc_we_a, 0);
    check_output("lu_if_id_we_a", if_id_we_a, 0);
    check_output("lu_bubble_a", bubble_a, 1);
    check_output("lu_bubble_b0", bubble_b, 1);
    tick();
    idle();
    check_output("lu_after_pc_we_a", pc_we_a, 1);
    check_output("lu_after_bubble_a", bubble_a, 0);
    check_output("lu_stall_a", stall_cnt_a, 1);
    check_output("lu_bubble_b1", bubble_b, 1);
    tick();
    check_output("lu_bubble_b2", bubble_b, 1);
    check_output("lu_pc_we_b2", pc_we_b, 0);
    tick();
    check_output("lu_bubble_b3", bubble_b, 0);
    check_output("lu_pc_we_b3", pc_we_b, 1);
    check_output("lu_stall_b", stall_cnt_b, 3);

    // hazard qualifiers
    apply_stimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("rd0_no_stall_a", bubble_a, 0);
    check_output("rd0_pc_we_b", pc_we_b, 1);
    apply_stimulus(1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("imm_rt_no_stall_a", bubble_a, 0);
    apply_stimulus(1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("rt_stall_a", bubble_a, 1);
    apply_stimulus(1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("no_wb_no_stall_b", bubble_b, 0);
    apply_stimulus(1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    check_output("not_ld_no_stall_a", bubble_a, 0);
    idle();

    // taken branch with simultaneous hazard
    apply_stimulus(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_output("br_pc_sel_a", pc_sel_a, 1);
    check_output("br_flush_a", flush_a, 3);
    check_output("br_bubble_a", bubble_a, 0);
    check_output("br_pc_we_b", pc_we_b, 1);
    check_output("br_if_id_we_b", if_id_we_b, 1);
    check_output("br_flush_b", flush_b, 3);
    tick();
    idle();
    check_output("br_flushcnt_a", flush_cnt_a, 1);
    check_output("br_flushcnt_b", flush_cnt_b, 1);
    check_output("br_stall_a", stall_cnt_a, 1);
    check_output("br_pc_sel_off_a", pc_sel_a, 0);

    // memory wait in the middle of b's bubble sequence
    apply_stimulus(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("mw_freeze_b%0d", i), freeze_b, 1);
      check_output($sformatf("mw_pc_we_a%0d", i), pc_we_a, 0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    check_output("mw_exit_freeze_b", freeze_b, 0);
    check_output("mw_exit_bubble_b", bubble_b, 1);
    check_output("mw_exit_pc_we_a", pc_we_a, 1);
    tick();
    check_output("mw_resume_bubble_b", bubble_b, 1);
    tick();
    check_output("mw_done_bubble_b", bubble_b, 0);
    check_output("mw_done_pc_we_b", pc_we_b, 1);
    check_output("mw_stall_a", stall_cnt_a, 6);
    check_output("mw_stall_b", stall_cnt_b, 10);
    idle();

    // flush counter saturation on the 4-bit instance
    branch_ex = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    branch_ex = 1'b0;
    #1;
    check_output("sat_flushcnt_b", flush_cnt_b, 15);
    check_output("sat_flushcnt_a", flush_cnt_a, 21);

    // stall saturation, then async reset while b waits with bubbles pending
    apply_stimulus(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check_output("sat_stall_b", stall_cnt_b, 15);
    check_output("sat_stall_a", stall_cnt_a, 17);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_stall_a", stall_cnt_a, 0);
    check_output("arst_flushcnt_b", flush_cnt_b, 0);
    mem_req = 1'b0;
    #1;
    check_output("arst_pc_we_b", pc_we_b, 1);
    check_output("arst_bubble_b", bubble_b, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check_output("post_rst_bubble_b", bubble_b, 0);
    check_output("post_rst_pc_we_b", pc_we_b, 1);

`ifdef PIPE_MEM_WATCHDOG_EN
    // watchdog: one entry cycle plus 15 MWAIT cycles of freeze, then release
    apply_stimulus(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    frz = 0;
    for (int i = 0; i < 40; i++) begin
      if (!freeze_a) break;
      frz++;
      tick();
    end
    check_output("wd_freeze_cycles", frz, 16);
    check_output("wd_mem_err_a", mem_err_a, 1);
    check_output("wd_freeze_a", freeze_a, 0);
    check_output("wd_pc_we_a", pc_we_a, 1);
    for (int i = 0; i < 4; i++) tick();
    idle();
    tick();
    check_output("wd_sticky_a", mem_err_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("wd_rst_clear_a", mem_err_a, 0);
    #1;
    rst_n = 1'b1;
    tick();
`else
    frz = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
